// File: rtl/multi_button_ctrl.sv
// rtl/multi_button_ctrl.sv - N-channel button synchroniser, debouncer and edge/long-press/repeat event generator
// Optional hold FSM (long-press and auto-repeat) is built when MULTI_BUTTON_REPEAT_EN is defined.
module multi_button_ctrl #(
    parameter int N_BTN        = 4,
    parameter int ACTIVE_LOW   = 1,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int LONG_CYC     = 25000000,
    parameter int REPEAT_CYC   = 5000000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_btn_state,
    output logic [N_BTN-1:0] o_flag_btn_down,
    output logic [N_BTN-1:0] o_flag_btn_up,
    output logic [N_BTN-1:0] o_flag_btn_long,
    output logic [N_BTN-1:0] o_flag_btn_rep
);

    localparam int             DW      = $clog2(DEBOUNCE_CYC) + 1;
    localparam logic [DW-1:0]  DB_TERM = DW'(DEBOUNCE_CYC - 1);
    localparam logic           REL_LVL = (ACTIVE_LOW != 0);

    if (N_BTN < 1 || N_BTN > 32 || DEBOUNCE_CYC < 1 || LONG_CYC < 1 || REPEAT_CYC < 1) begin : g_bad_param
        $error("multi_button_ctrl: parameter out of range");
    end

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] pressed_raw;

    // Synchroniser idles at the released pin level so reset never looks like a press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= {N_BTN{REL_LVL}};
            sync2 <= {N_BTN{REL_LVL}};
        end else begin
            sync1 <= i_btn;
            sync2 <= sync1;
        end
    end

    assign pressed_raw = sync2 ^ {N_BTN{REL_LVL}};

`ifdef MULTI_BUTTON_REPEAT_EN
    localparam int            HMAX      = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
    localparam int            HW        = $clog2(HMAX) + 1;
    localparam logic [HW-1:0] LONG_TERM = HW'(LONG_CYC - 1);
    localparam logic [HW-1:0] REP_TERM  = HW'(REPEAT_CYC - 1);

    typedef enum logic [1:0] {
        ST_REL  = 2'd0,
        ST_HOLD = 2'd1,
        ST_LONG = 2'd2
    } hold_st_t;
`endif

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [DW-1:0] db_cnt;
        logic          state_q;
        logic          down_q;
        logic          up_q;
        logic          mismatch;
        logic          accept;

        assign mismatch = pressed_raw[i] ^ state_q;
        assign accept   = mismatch && (db_cnt == DB_TERM);

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                db_cnt  <= '0;
                state_q <= 1'b0;
                down_q  <= 1'b0;
                up_q    <= 1'b0;
            end else begin
                down_q <= accept & ~state_q;
                up_q   <= accept & state_q;
                if (!mismatch || accept) begin
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
                if (accept) begin
                    state_q <= ~state_q;
                end
            end
        end

        assign o_btn_state[i]     = state_q;
        assign o_flag_btn_down[i] = down_q;
        assign o_flag_btn_up[i]   = up_q;

`ifdef MULTI_BUTTON_REPEAT_EN
        hold_st_t      hold_st;
        logic [HW-1:0] hold_cnt;
        logic          long_q;
        logic          rep_q;

        // A release accepted on the same edge as a terminal count wins over long/repeat.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                hold_st  <= ST_REL;
                hold_cnt <= '0;
                long_q   <= 1'b0;
                rep_q    <= 1'b0;
            end else begin
                long_q <= 1'b0;
                rep_q  <= 1'b0;
                case (hold_st)
                    ST_REL: begin
                        hold_cnt <= '0;
                        if (accept && !state_q) begin
                            hold_st <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (accept) begin
                            hold_st  <= ST_REL;
                            hold_cnt <= '0;
                        end else if (hold_cnt == LONG_TERM) begin
                            long_q   <= 1'b1;
                            hold_cnt <= '0;
                            hold_st  <= ST_LONG;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    ST_LONG: begin
                        if (accept) begin
                            hold_st  <= ST_REL;
                            hold_cnt <= '0;
                        end else if (hold_cnt == REP_TERM) begin
                            rep_q    <= 1'b1;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    default: begin
                        hold_st  <= ST_REL;
                        hold_cnt <= '0;
                    end
                endcase
            end
        end

        assign o_flag_btn_long[i] = long_q;
        assign o_flag_btn_rep[i]  = rep_q;
`endif
    end

`ifndef MULTI_BUTTON_REPEAT_EN
    assign o_flag_btn_long = '0;
    assign o_flag_btn_rep  = '0;
`endif

endmodule

// File: tb/tb_multi_button_ctrl.sv
// tb/tb_multi_button_ctrl.sv - directed self-checking bench for multi_button_ctrl
module tb_multi_button_ctrl;

`ifdef MULTI_BUTTON_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] btn;
    logic [3:0] state;
    logic [3:0] down;
    logic [3:0] up;
    logic [3:0] long_f;
    logic [3:0] rep_f;

    int checks;
    int errors;

    multi_button_ctrl #(
        .N_BTN       (4),
        .ACTIVE_LOW  (1),
        .DEBOUNCE_CYC(8),
        .LONG_CYC    (40),
        .REPEAT_CYC  (10)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_btn          (btn),
        .o_btn_state    (state),
        .o_flag_btn_down(down),
        .o_flag_btn_up  (up),
        .o_flag_btn_long(long_f),
        .o_flag_btn_rep (rep_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn   = 4'hF;
        #2;
        checks++;
        if ({state, down, up, long_f, rep_f} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 00000", {state, down, up, long_f, rep_f});
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if ({state, down, up, long_f, rep_f} !== 20'h0) begin
                errors++;
                $display("FAIL idle_after_reset got %h want 00000", {state, down, up, long_f, rep_f});
            end
        end
    endtask

    task automatic test_press_release();
        btn[0] = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            checks++;
            if (down !== 4'b0000 || state !== 4'b0000) begin
                errors++;
                $display("FAIL press0_early cyc %0d down %b state %b want 0000", k, down, state);
            end
        end
        tick();
        checks++;
        if (down !== 4'b0001 || state !== 4'b0001) begin
            errors++;
            $display("FAIL press0_edge down %b state %b want 0001 0001", down, state);
        end
        tick();
        checks++;
        if (down !== 4'b0000 || state !== 4'b0001) begin
            errors++;
            $display("FAIL press0_one_cycle down %b state %b want 0000 0001", down, state);
        end
        btn[0] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            checks++;
            if (up !== 4'b0000 || state !== 4'b0001) begin
                errors++;
                $display("FAIL release0_early cyc %0d up %b state %b want 0000 0001", k, up, state);
            end
        end
        tick();
        checks++;
        if (up !== 4'b0001 || state !== 4'b0000 || down !== 4'b0000) begin
            errors++;
            $display("FAIL release0_edge up %b state %b down %b want 0001 0000 0000", up, state, down);
        end
        tick();
        checks++;
        if (up !== 4'b0000) begin
            errors++;
            $display("FAIL release0_one_cycle up %b want 0000", up);
        end
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 27; k++) begin
            if (k < 5)       btn[1] = 1'b0;
            else if (k < 7)  btn[1] = 1'b1;
            else if (k < 12) btn[1] = 1'b0;
            else             btn[1] = 1'b1;
            tick();
            checks++;
            if ({state, down, up, long_f, rep_f} !== 20'h0) begin
                errors++;
                $display("FAIL bounce cyc %0d got %h want 00000", k, {state, down, up, long_f, rep_f});
            end
        end
    endtask

    task automatic test_long_repeat();
        logic [3:0] exp_long;
        logic [3:0] exp_rep;
        logic [3:0] exp_up;
        btn[2] = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            checks++;
            if (down !== 4'b0000) begin
                errors++;
                $display("FAIL press2_early cyc %0d down %b want 0000", k, down);
            end
        end
        tick();
        checks++;
        if (down !== 4'b0100 || state !== 4'b0100) begin
            errors++;
            $display("FAIL press2_edge down %b state %b want 0100 0100", down, state);
        end
        for (int k = 1; k <= 100; k++) begin
            tick();
            exp_long = (REP_EN && k == 40) ? 4'b0100 : 4'b0000;
            exp_rep  = (REP_EN && k >= 50 && (k % 10) == 0) ? 4'b0100 : 4'b0000;
            checks++;
            if (long_f !== exp_long || rep_f !== exp_rep || down !== 4'b0000 || up !== 4'b0000) begin
                errors++;
                $display("FAIL hold2 cyc %0d long %b rep %b down %b up %b want %b %b 0000 0000",
                         k, long_f, rep_f, down, up, exp_long, exp_rep);
            end
        end
        btn[2] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp_up = (k == 10) ? 4'b0100 : 4'b0000;
            checks++;
            if (up !== exp_up || rep_f !== 4'b0000 || long_f !== 4'b0000) begin
                errors++;
                $display("FAIL release2 cyc %0d up %b rep %b long %b want %b 0000 0000",
                         k, up, rep_f, long_f, exp_up);
            end
        end
        checks++;
        if (state !== 4'b0000) begin
            errors++;
            $display("FAIL release2_state got %b want 0000", state);
        end
    endtask

    task automatic test_back_to_back();
        btn = 4'b0110;
        for (int k = 1; k <= 9; k++) begin
            tick();
            checks++;
            if (down !== 4'b0000) begin
                errors++;
                $display("FAIL dual_early cyc %0d down %b want 0000", k, down);
            end
        end
        tick();
        checks++;
        if (down !== 4'b1001 || state !== 4'b1001 || up !== 4'b0000) begin
            errors++;
            $display("FAIL dual_edge down %b state %b up %b want 1001 1001 0000", down, state, up);
        end
        btn = 4'hF;
        for (int k = 1; k <= 9; k++) begin
            tick();
            checks++;
            if (up !== 4'b0000 || down !== 4'b0000) begin
                errors++;
                $display("FAIL dual_rel_early cyc %0d up %b down %b want 0000 0000", k, up, down);
            end
        end
        tick();
        checks++;
        if (up !== 4'b1001 || state !== 4'b0000) begin
            errors++;
            $display("FAIL dual_rel_edge up %b state %b want 1001 0000", up, state);
        end
        tick();
    endtask

    task automatic test_reset_mid_hold();
        logic [3:0] exp_long;
        btn[2] = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        checks++;
        if (down !== 4'b0100) begin
            errors++;
            $display("FAIL rh_press down %b want 0100", down);
        end
        for (int k = 1; k <= 45; k++) tick();
        checks++;
        if (state !== 4'b0100) begin
            errors++;
            $display("FAIL rh_held state %b want 0100", state);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state, down, up, long_f, rep_f} !== 20'h0) begin
            errors++;
            $display("FAIL rh_async_reset got %h want 00000", {state, down, up, long_f, rep_f});
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({state, down, up, long_f, rep_f} !== 20'h0) begin
                errors++;
                $display("FAIL rh_in_reset got %h want 00000", {state, down, up, long_f, rep_f});
            end
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            checks++;
            if (down !== 4'b0000 || up !== 4'b0000) begin
                errors++;
                $display("FAIL rh_fresh_early cyc %0d down %b up %b want 0000 0000", k, down, up);
            end
        end
        tick();
        checks++;
        if (down !== 4'b0100 || state !== 4'b0100) begin
            errors++;
            $display("FAIL rh_fresh_edge down %b state %b want 0100 0100", down, state);
        end
        for (int k = 1; k <= 40; k++) begin
            tick();
            exp_long = (REP_EN && k == 40) ? 4'b0100 : 4'b0000;
            checks++;
            if (long_f !== exp_long || rep_f !== 4'b0000) begin
                errors++;
                $display("FAIL rh_long cyc %0d long %b rep %b want %b 0000", k, long_f, rep_f, exp_long);
            end
        end
        btn[2] = 1'b1;
        for (int k = 1; k <= 10; k++) tick();
        checks++;
        if (up !== 4'b0100 || state !== 4'b0000) begin
            errors++;
            $display("FAIL rh_release up %b state %b want 0100 0000", up, state);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        btn    = 4'hF;
        test_reset();
        test_press_release();
        test_bounce();
        test_long_repeat();
        test_back_to_back();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
